// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and Gray-code helpers for the async FIFO controllers.
// Latency: n/a (package; functions are pure combinational).
// Backpressure: n/a.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Widest pointer the helpers handle. Callers zero-extend narrower pointers in
  // and truncate the result back; the extra high bits stay zero through both
  // conversions, so the low bits are exactly the narrow-width answer.
  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: multi-flop synchroniser for a Gray pointer crossing clock domains.
// Latency: STAGES cycles of the destination clock.
// Backpressure: none; free-running every cycle.
// Ports: clk/reset_n destination clock and async active-low reset,
//        ptr_i Gray pointer from the other domain, ptr_o synchronised copy.
module gray_ptr_sync #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ptr_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ptr_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter and write-pointer owner for the async FIFO.
// Latency: transfer in cycle T -> mem_we in T+1; wr_ptr_gray follows one cycle after that.
// Backpressure: both readys drop while full; full clears only via the synchronised read pointer.
// Ports: req0/req1 valid/ready/data requesters; rd_ptr_gray from the read domain;
//        mem_we/mem_waddr/mem_wdata to the RAM; wr_ptr_gray to the read domain;
//        full/almost_full/level status in the write domain.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level
);

  localparam int            PW        = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0]     wr_bin_q, wr_bin_d;
  logic [PW-1:0]     wr_gray_q, wr_gray_next;
  logic [PW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              prio_q, prio_d;       // 0: req0 wins a tie, 1: req1 wins
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [PW-1:0]     rd_gray_s, rd_bin_s, full_cmp;
  logic              gnt0, gnt1, xfer;
  logic [DATA_W-1:0] xfer_dat;

  gray_ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .ptr_i   (rd_ptr_gray),
    .ptr_o   (rd_gray_s)
  );

  always_comb begin
    gnt0     = req0_valid & (~req1_valid | ~prio_q);
    gnt1     = req1_valid & (~req0_valid |  prio_q);
    xfer     = (gnt0 | gnt1) & ~full_q;
    xfer_dat = gnt1 ? req1_data : req0_data;
    // The winner of a transfer hands priority to the other requester.
    prio_d   = xfer ? gnt0 : prio_q;

    wr_bin_d     = wr_bin_q + PW'(xfer);
    wr_gray_next = PW'(bin2gray(PTR_MAX_W'(wr_bin_d)));
    rd_bin_s     = PW'(gray2bin(PTR_MAX_W'(rd_gray_s)));

    // Full when the writer is exactly one lap ahead: in Gray that is the read
    // pointer with its top two bits inverted.
    full_cmp = {~rd_gray_s[ADDR_W:ADDR_W-1], rd_gray_s[ADDR_W-2:0]};
    full_d   = (wr_gray_next == full_cmp);
    level_d  = wr_bin_d - rd_bin_s;
    afull_d  = (level_d >= AFULL_LVL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bin_q    <= '0;
      wr_gray_q   <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      prio_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      // Published from the current wr_bin, so it moves only once the RAM write
      // for that slot has been issued and can never run ahead of the data.
      wr_gray_q <= PW'(bin2gray(PTR_MAX_W'(wr_bin_q)));
      level_q   <= level_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      prio_q    <= prio_d;
      mem_we_q  <= xfer;
      if (xfer) begin
        mem_waddr_q <= wr_bin_q[ADDR_W-1:0];
        mem_wdata_q <= xfer_dat;
      end
    end
  end

  assign req0_ready  = gnt0 & ~full_q;
  assign req1_ready  = gnt1 & ~full_q;
  assign mem_we      = mem_we_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ptr_gray = wr_gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign level       = level_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for the FIFO write arbiter.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [4:0] rd_ptr_gray;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [4:0] wr_ptr_gray;
  logic       full, almost_full;
  logic [4:0] level;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2), .AFULL_THRESH(12)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_ptr_gray(rd_ptr_gray),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full), .level(level)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;

  // Reference model of the registered outputs as they stand after the last edge.
  int         m_total, m_wr, m_level, m_s1, m_s2;
  logic       m_prio, m_full, m_afull;
  logic [4:0] m_gray;

  int         cnt0, cnt1, rd_bin_tb;
  logic [7:0] base0, base1;
  bit         track, saw_full, gray_wrap, addr_wrap;
  logic [7:0] gnt_hist;
  logic [4:0] prev_gray;
  logic [3:0] last_waddr;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic drive_data();
    req0_data = base0 + 8'(cnt0);
    req1_data = base1 + 8'(cnt1);
  endtask

  task automatic apply_reset();
    reset_n     = 1'b0;
    rd_bin_tb   = 0;
    rd_ptr_gray = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_wr_gray", 32'(wr_ptr_gray), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    m_total = 0; m_wr = 0; m_level = 0; m_s1 = 0; m_s2 = 0;
    m_prio = 1'b0; m_full = 1'b0; m_afull = 1'b0; m_gray = 5'd0;
    exp_q.delete();
    cnt0 = 0; cnt1 = 0;
    prev_gray = 5'd0; last_waddr = 4'd0;
    drive_data();
    reset_n = 1'b1;
  endtask

  // One clock: compare at the falling edge, advance the model, then drive
  // the next inputs just after the rising edge.
  task automatic cyc();
    wr_t  e;
    logic e0, e1;
    @(negedge clk);
    chk("mem_we", 32'(mem_we), 32'(exp_q.size() != 0));
    if (mem_we && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("mem_waddr", 32'(mem_waddr), 32'(e.addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
      if (last_waddr == 4'd15 && mem_waddr == 4'd0) addr_wrap = 1'b1;
      last_waddr = mem_waddr;
    end
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(m_gray));
    chk("full", 32'(full), 32'(m_full));
    chk("level", 32'(level), 32'(m_level));
    chk("almost_full", 32'(almost_full), 32'(m_afull));

    e0 = req0_valid && (!req1_valid || !m_prio) && !m_full;
    e1 = req1_valid && (!req0_valid ||  m_prio) && !m_full;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    gnt_hist = {gnt_hist[6:0], req1_ready};

    m_gray = gray5(m_wr);
    if (e0 || e1) begin
      exp_q.push_back('{addr: 4'(m_wr), data: (e1 ? req1_data : req0_data)});
      m_wr = (m_wr + 1) % 32;
      m_total++;
      m_prio = e0;
    end
    m_level = (m_wr - m_s2) & 31;
    m_full  = (m_level == 16);
    m_afull = (m_level >= 12);
    m_s2 = m_s1;
    m_s1 = rd_bin_tb;

    @(posedge clk);
    #1;
    if (e0) cnt0++;
    if (e1) cnt1++;
    drive_data();
    if (track) rd_bin_tb = (m_total >= 2) ? (m_total - 2) % 32 : 0;
    rd_ptr_gray = gray5(rd_bin_tb);
    if (full) saw_full = 1'b1;
    if (prev_gray == 5'b10000 && wr_ptr_gray == 5'b00000) gray_wrap = 1'b1;
    prev_gray = wr_ptr_gray;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; track = 1'b0; saw_full = 1'b0; gray_wrap = 1'b0; addr_wrap = 1'b0;
    gnt_hist = 8'd0; base0 = 8'hA0; base1 = 8'h50; cnt0 = 0; cnt1 = 0;
    rd_bin_tb = 0; rd_ptr_gray = 5'd0;
    drive_data();

    // Reset with both requesters asserting; req0 holds priority afterwards.
    req0_valid = 1'b1; req1_valid = 1'b1;
    apply_reset();
    chk("post_rst_rdy0", 32'(req0_ready), 32'd1);
    chk("post_rst_rdy1", 32'(req1_ready), 32'd0);

    // Fill: req0 streams A0..AF with the reader parked at 0.
    req1_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("afull_edge", 32'(almost_full), 32'(i >= 12));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    req1_valid = 1'b1;
    chk("full_rdy0", 32'(req0_ready), 32'd0);
    chk("full_rdy1", 32'(req1_ready), 32'd0);
    repeat (2) cyc();

    // Drain: reader moves to 4 (Gray 6); status recovers after sync + 1.
    req1_valid = 1'b0;
    rd_bin_tb = 4;
    rd_ptr_gray = gray5(rd_bin_tb);
    repeat (3) cyc();
    chk("drain_full", 32'(full), 32'd0);
    chk("drain_level", 32'(level), 32'd12);
    chk("drain_afull", 32'(almost_full), 32'd1);
    chk("drain_rdy0", 32'(req0_ready), 32'd1);
    repeat (6) cyc();

    // Fairness: both valid alternate, then a lone req1 streams every cycle.
    req0_valid = 1'b1; req1_valid = 1'b1; track = 1'b1;
    apply_reset();
    repeat (8) cyc();
    chk("alternate", 32'(gnt_hist[3:0]), 32'b0101);
    req0_valid = 1'b0;
    repeat (6) cyc();
    chk("req1_b2b", 32'(gnt_hist[5:0]), 32'b111111);
    req1_valid = 1'b0;
    repeat (3) cyc();

    // Wrap: 40 writes with the reader two behind.
    req0_valid = 1'b1;
    apply_reset();
    saw_full = 1'b0; gray_wrap = 1'b0; addr_wrap = 1'b0;
    repeat (40) cyc();
    req0_valid = 1'b0;
    repeat (4) cyc();
    chk("wrap_no_full", 32'(saw_full), 32'd0);
    chk("wrap_gray", 32'(gray_wrap), 32'd1);
    chk("wrap_waddr", 32'(addr_wrap), 32'd1);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Mid-burst reset: mem_we must drop asynchronously.
    req0_valid = 1'b1;
    repeat (5) cyc();
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_gray", 32'(wr_ptr_gray), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    apply_reset();
    cyc();
    chk("post_rst_we", 32'(mem_we), 32'd1);
    chk("post_rst_addr", 32'(mem_waddr), 32'd0);
    req0_valid = 1'b0;
    repeat (4) cyc();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
